// File: rtl/rob_mp_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rob_mp_pkg                                                |
// | Purpose  : Shared defaults, kind codes and entry layout for rob_mp.  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package rob_mp_pkg;

  localparam int ROB_DEPTH    = 16;
  localparam int ROB_IDX_W    = $clog2(ROB_DEPTH);
  localparam int ROB_WB_PORTS = 2;
  localparam int ROB_Q_PORTS  = 2;

  // Writeback payload packs {mispred, redirect, value}.
  localparam int WB_PAY_W = 1 + 32 + 32;

  typedef enum logic [2:0] {
    ROBK_REG    = 3'd0,
    ROBK_STORE  = 3'd1,
    ROBK_BRANCH = 3'd2,
    ROBK_JALR   = 3'd3,
    ROBK_NOP    = 3'd4
  } rob_kind_t;

  typedef struct packed {
    logic        busy;
    logic        done;
    rob_kind_t   kind;
    logic [4:0]  rd;
    logic [31:0] value;
    logic        mispred;
    logic [31:0] redirect;
  } rob_entry_t;

  function automatic logic kind_writes_rd(rob_kind_t k);
    return (k == ROBK_REG) || (k == ROBK_JALR);
  endfunction

endpackage
`default_nettype wire

// File: rtl/rob_mp_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rob_mp_if                                                 |
// | Purpose  : Issue / writeback / query / commit bundle of rob_mp.      |
// |            slave = ROB side, master = surrounding pipeline.          |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
interface rob_mp_if
  import rob_mp_pkg::*;
#(
  parameter int IDX_W    = ROB_IDX_W,
  parameter int WB_PORTS = ROB_WB_PORTS,
  parameter int Q_PORTS  = ROB_Q_PORTS
) ();

  logic                      issue_valid;
  logic [2:0]                issue_kind;
  logic [4:0]                issue_rd;
  logic [31:0]               issue_pc;
  logic [31:0]               issue_value;
  logic                      issue_done;
  logic                      full;
  logic [IDX_W-1:0]          alloc_id;
  logic [IDX_W:0]            count;

  logic [WB_PORTS-1:0]       wb_valid;
  logic [WB_PORTS*IDX_W-1:0] wb_id;
  logic [WB_PORTS*32-1:0]    wb_value;
  logic [WB_PORTS-1:0]       wb_mispred;
  logic [WB_PORTS*32-1:0]    wb_redirect;

  logic [Q_PORTS*IDX_W-1:0]  q_id;
  logic [Q_PORTS-1:0]        q_ready;
  logic [Q_PORTS*32-1:0]     q_value;

  logic                      commit_valid;
  logic [IDX_W-1:0]          commit_id;
  logic [4:0]                commit_rd;
  logic [31:0]               commit_value;
  logic                      st_commit_req;
  logic                      st_commit_ack;
  logic [IDX_W-1:0]          head_id;
  logic                      flush;
  logic [31:0]               flush_pc;

  modport slave (
    input  issue_valid, issue_kind, issue_rd, issue_pc, issue_value, issue_done,
    input  wb_valid, wb_id, wb_value, wb_mispred, wb_redirect,
    input  q_id, st_commit_ack,
    output full, alloc_id, count, q_ready, q_value,
    output commit_valid, commit_id, commit_rd, commit_value,
    output st_commit_req, head_id, flush, flush_pc
  );

  modport master (
    output issue_valid, issue_kind, issue_rd, issue_pc, issue_value, issue_done,
    output wb_valid, wb_id, wb_value, wb_mispred, wb_redirect,
    output q_id, st_commit_ack,
    input  full, alloc_id, count, q_ready, q_value,
    input  commit_valid, commit_id, commit_rd, commit_value,
    input  st_commit_req, head_id, flush, flush_pc
  );

endinterface
`default_nettype wire

// File: rtl/rob_mp_wb_sel.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rob_mp_wb_sel                                             |
// | Purpose  : Tag match of one query against all writeback ports; the   |
// |            highest matching port index supplies the data.            |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module rob_mp_wb_sel
  import rob_mp_pkg::*;
#(
  parameter int IDX_W    = ROB_IDX_W,
  parameter int WB_PORTS = ROB_WB_PORTS,
  parameter int W        = 32
) (
  input  logic [IDX_W-1:0]          q_id,
  input  logic [WB_PORTS-1:0]       wb_valid,
  input  logic [WB_PORTS*IDX_W-1:0] wb_id,
  input  logic [WB_PORTS*W-1:0]     wb_data,
  output logic                      hit,
  output logic [W-1:0]              data
);

  always_comb begin
    hit  = 1'b0;
    data = '0;
    // Ascending scan so a later (higher) port overrides an earlier one.
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb_valid[p] && (wb_id[p*IDX_W +: IDX_W] == q_id)) begin
        hit  = 1'b1;
        data = wb_data[p*W +: W];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/rob_mp.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : rob_mp                                                    |
// | Purpose  : Parametrised reorder buffer with N writeback ports,       |
// |            store-commit handshake and mispredict redirect.           |
// |            Define ROB_WB_BYPASS_EN for zero-cycle query forwarding.  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module rob_mp
  import rob_mp_pkg::*;
#(
  parameter int DEPTH    = ROB_DEPTH,
  parameter int IDX_W    = ROB_IDX_W,
  parameter int WB_PORTS = ROB_WB_PORTS,
  parameter int Q_PORTS  = ROB_Q_PORTS
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     rdy,
  rob_mp_if.slave  bus
);

  rob_entry_t                   ent_q [DEPTH];
  rob_entry_t                   ent_d [DEPTH];
  logic [IDX_W-1:0]             head_q, head_d, tail_q, tail_d;
  logic [IDX_W:0]               count_q, count_d;

  logic [DEPTH-1:0]             wb_hit;
  logic [WB_PAY_W-1:0]          wb_pay [DEPTH];
  logic [WB_PORTS*WB_PAY_W-1:0] wb_pay_in;

  rob_entry_t                   head_ent;
  logic                         full, commit_fire, st_req, retire, flush, issue_acc;
  logic [Q_PORTS-1:0]           q_ready;
  logic [Q_PORTS*32-1:0]        q_value;

  for (genvar p = 0; p < WB_PORTS; p++) begin : g_pay
    assign wb_pay_in[p*WB_PAY_W +: WB_PAY_W] =
      {bus.wb_mispred[p], bus.wb_redirect[p*32 +: 32], bus.wb_value[p*32 +: 32]};
  end

  for (genvar e = 0; e < DEPTH; e++) begin : g_entry
    rob_mp_wb_sel #(.IDX_W(IDX_W), .WB_PORTS(WB_PORTS), .W(WB_PAY_W)) u_sel (
      .q_id     (IDX_W'(e)),
      .wb_valid (bus.wb_valid),
      .wb_id    (bus.wb_id),
      .wb_data  (wb_pay_in),
      .hit      (wb_hit[e]),
      .data     (wb_pay[e])
    );
  end

  assign head_ent    = ent_q[head_q];
  assign full        = (count_q == (IDX_W+1)'(DEPTH));
  assign commit_fire = rdy & head_ent.busy & head_ent.done & (head_ent.kind != ROBK_STORE);
  assign st_req      = rdy & head_ent.busy & head_ent.done & (head_ent.kind == ROBK_STORE);
  assign retire      = commit_fire | (st_req & bus.st_commit_ack);
  assign flush       = retire & head_ent.mispred;
  assign issue_acc   = rdy & bus.issue_valid & ~full & ~flush;

  always_comb begin
    ent_d   = ent_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q + (IDX_W+1)'(issue_acc) - (IDX_W+1)'(retire);
    for (int e = 0; e < DEPTH; e++) begin
      if (wb_hit[e] && ent_q[e].busy) begin
        ent_d[e].done = 1'b1;
        {ent_d[e].mispred, ent_d[e].redirect, ent_d[e].value} = wb_pay[e];
      end
    end
    if (retire) begin
      ent_d[head_q].busy = 1'b0;
      ent_d[head_q].done = 1'b0;
      head_d             = head_q + IDX_W'(1);
    end
    if (issue_acc) begin
      ent_d[tail_q] = '{busy: 1'b1, done: bus.issue_done, kind: rob_kind_t'(bus.issue_kind),
                        rd: bus.issue_rd, value: bus.issue_value, mispred: 1'b0,
                        redirect: bus.issue_pc + 32'd4};
      tail_d        = tail_q + IDX_W'(1);
    end
    if (flush) begin
      for (int e = 0; e < DEPTH; e++) ent_d[e] = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && rdy) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int e = 0; e < DEPTH; e++) ent_q[e] <= '0;
    end else if (rdy) begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int e = 0; e < DEPTH; e++) ent_q[e] <= ent_d[e];
    end
  end

  for (genvar q = 0; q < Q_PORTS; q++) begin : g_query
    logic [IDX_W-1:0] qid;
    assign qid = bus.q_id[q*IDX_W +: IDX_W];
`ifdef ROB_WB_BYPASS_EN
    logic        byp_hit, live_hit, iss_hit;
    logic [31:0] byp_val;
    rob_mp_wb_sel #(.IDX_W(IDX_W), .WB_PORTS(WB_PORTS), .W(32)) u_byp (
      .q_id     (qid),
      .wb_valid (bus.wb_valid),
      .wb_id    (bus.wb_id),
      .wb_data  (bus.wb_value),
      .hit      (byp_hit),
      .data     (byp_val)
    );
    // Live writebacks only count for allocated tags, matching the drop rule.
    assign live_hit = byp_hit & ent_q[qid].busy;
    assign iss_hit  = issue_acc & bus.issue_done & (qid == tail_q);
    assign q_ready[q]           = ent_q[qid].done | live_hit | iss_hit;
    assign q_value[q*32 +: 32]  = live_hit ? byp_val :
                                  iss_hit  ? bus.issue_value : ent_q[qid].value;
`else
    assign q_ready[q]           = ent_q[qid].done;
    assign q_value[q*32 +: 32]  = ent_q[qid].value;
`endif
  end

  assign bus.full          = full;
  assign bus.alloc_id      = tail_q;
  assign bus.count         = count_q;
  assign bus.q_ready       = q_ready;
  assign bus.q_value       = q_value;
  assign bus.commit_valid  = commit_fire;
  assign bus.commit_id     = head_q;
  assign bus.commit_rd     = (commit_fire && kind_writes_rd(head_ent.kind)) ? head_ent.rd : '0;
  assign bus.commit_value  = commit_fire ? head_ent.value : '0;
  assign bus.st_commit_req = st_req;
  assign bus.head_id       = head_q;
  assign bus.flush         = flush;
  assign bus.flush_pc      = flush ? head_ent.redirect : '0;

endmodule
`default_nettype wire

// File: tb/tb_rob_mp.sv
`default_nettype none
// Testbench for rob_mp: directed scenarios plus random traffic, all outputs
// compared every cycle against a queue-based reorder-buffer model.
module tb_rob_mp;
  import rob_mp_pkg::*;

  localparam int DEPTH = 16;
  localparam int IDX_W = 4;
  localparam int WBP   = 2;
  localparam int QP    = 2;

  logic clk = 1'b0;
  logic rst, rdy;
  always #5 clk = ~clk;

  rob_mp_if #(.IDX_W(IDX_W), .WB_PORTS(WBP), .Q_PORTS(QP)) bus ();
  rob_mp #(.DEPTH(DEPTH), .IDX_W(IDX_W), .WB_PORTS(WBP), .Q_PORTS(QP)) dut (
    .clk (clk), .rst (rst), .rdy (rdy), .bus (bus)
  );

  logic        iv, idn, ack;
  logic [2:0]  ik;
  logic [4:0]  ird;
  logic [31:0] ipc, ival;
  logic        wv   [WBP];
  logic [3:0]  wid  [WBP];
  logic [31:0] wval [WBP];
  logic        wmp  [WBP];
  logic [31:0] wred [WBP];
  logic [3:0]  qid  [QP];

  typedef struct {
    int          id;
    int          kind;
    logic [4:0]  rd;
    logic [31:0] value;
    bit          done;
    bit          mispred;
    logic [31:0] redirect;
  } m_ent_t;

  m_ent_t mq [$];
  int     m_head, m_tail;
  bit     m_retire, m_flush, m_issue;
  int     n_pass = 0, n_total = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    iv = 0; idn = 0; ack = 0; ik = 0; ird = 0; ipc = 0; ival = 0;
    for (int p = 0; p < WBP; p++) begin
      wv[p] = 0; wid[p] = 0; wval[p] = 0; wmp[p] = 0; wred[p] = 0;
    end
    for (int q = 0; q < QP; q++) qid[q] = 0;
  endtask

  task automatic drive();
    bus.issue_valid = iv; bus.issue_kind = ik; bus.issue_rd = ird;
    bus.issue_pc = ipc; bus.issue_value = ival; bus.issue_done = idn;
    bus.st_commit_ack = ack;
    for (int p = 0; p < WBP; p++) begin
      bus.wb_valid[p]                = wv[p];
      bus.wb_id[p*IDX_W +: IDX_W]    = wid[p];
      bus.wb_value[p*32 +: 32]       = wval[p];
      bus.wb_mispred[p]              = wmp[p];
      bus.wb_redirect[p*32 +: 32]    = wred[p];
    end
    for (int q = 0; q < QP; q++) bus.q_id[q*IDX_W +: IDX_W] = qid[q];
  endtask

  function automatic int find_id(input int id);
    for (int i = 0; i < mq.size(); i++) if (mq[i].id == id) return i;
    return -1;
  endfunction

  task automatic check_outputs();
    int n, k;
    bit cv, st, r;
    logic [31:0] v;
    n = mq.size();
    chk("count", bus.count, n);
    chk("full", bus.full, n == DEPTH);
    chk("alloc_id", bus.alloc_id, m_tail);
    chk("head_id", bus.head_id, m_head);
    cv = 0; st = 0;
    if (n > 0 && mq[0].done) begin
      cv = rdy && (mq[0].kind != ROBK_STORE);
      st = (mq[0].kind == ROBK_STORE);
    end
    chk("commit_valid", bus.commit_valid, cv);
    if (cv) begin
      chk("commit_id", bus.commit_id, m_head);
      chk("commit_rd", bus.commit_rd,
          (mq[0].kind == ROBK_REG || mq[0].kind == ROBK_JALR) ? mq[0].rd : 5'd0);
      chk("commit_value", bus.commit_value, mq[0].value);
    end
    if (rdy) chk("st_commit_req", bus.st_commit_req, st);
    m_retire = cv || (rdy && st && ack);
    m_flush  = m_retire && mq[0].mispred;
    chk("flush", bus.flush, m_flush);
    if (m_flush) chk("flush_pc", bus.flush_pc, mq[0].redirect);
    m_issue = rdy && iv && (n < DEPTH) && !m_flush;
    for (int q = 0; q < QP; q++) begin
      k = find_id(qid[q]);
      r = 0; v = 0;
      if (k >= 0 && mq[k].done) begin r = 1; v = mq[k].value; end
`ifdef ROB_WB_BYPASS_EN
      if (m_issue && idn && qid[q] == m_tail) begin r = 1; v = ival; end
      if (k >= 0)
        for (int p = 0; p < WBP; p++)
          if (wv[p] && wid[p] == qid[q]) begin r = 1; v = wval[p]; end
`endif
      chk("q_ready", bus.q_ready[q], r);
      if (r) chk("q_value", bus.q_value[q*32 +: 32], v);
    end
  endtask

  task automatic model_update();
    int k;
    m_ent_t e;
    if (!rdy) return;
    if (rst) begin mq.delete(); m_head = 0; m_tail = 0; return; end
    for (int p = 0; p < WBP; p++) begin
      if (wv[p]) begin
        k = find_id(wid[p]);
        if (k >= 0) begin
          mq[k].done = 1; mq[k].value = wval[p];
          mq[k].mispred = wmp[p]; mq[k].redirect = wred[p];
        end
      end
    end
    if (m_flush) begin
      mq.delete(); m_head = 0; m_tail = 0;
    end else begin
      if (m_retire) begin void'(mq.pop_front()); m_head = (m_head + 1) % DEPTH; end
      if (m_issue) begin
        e.id = m_tail; e.kind = ik; e.rd = ird; e.value = ival;
        e.done = idn; e.mispred = 0; e.redirect = 0;
        mq.push_back(e);
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
  endtask

  task automatic settle();  drive(); #1; endtask
  task automatic advance(); @(posedge clk); model_update(); @(negedge clk); endtask
  task automatic tick();    settle(); check_outputs(); advance(); endtask

  task automatic issue_set(input logic [2:0] kind, input logic [4:0] rd,
                           input logic done, input logic [31:0] val);
    iv = 1; ik = kind; ird = rd; idn = done; ival = val; ipc = $urandom;
  endtask

  task automatic do_reset();
    idle(); rst = 1; tick(); rst = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    bit seen;
    idle(); rst = 1; rdy = 1; drive();
    repeat (2) @(posedge clk);
    @(negedge clk);
    mq.delete(); m_head = 0; m_tail = 0; rst = 0;
    tick();

    // Reset while entries are in flight
    for (int i = 0; i < 3; i++) begin issue_set(ROBK_REG, 5'(i + 1), 0, i); tick(); end
    rst = 1; issue_set(ROBK_REG, 7, 0, 0); tick(); rst = 0; idle();
    settle();
    chk("rst_count", bus.count, 0);
    chk("rst_alloc", bus.alloc_id, 0);
    chk("rst_commit", bus.commit_valid, 0);
    check_outputs(); advance();

    // Fill to DEPTH; the 17th issue must be ignored
    for (int i = 0; i < DEPTH; i++) begin issue_set(ROBK_NOP, 0, 0, 0); tick(); end
    settle();
    chk("fill_full", bus.full, 1);
    chk("fill_count", bus.count, 16);
    check_outputs(); advance(); idle();
    settle();
    chk("fill_alloc", bus.alloc_id, 0);
    chk("fill_count_after", bus.count, 16);
    check_outputs(); advance();
    do_reset();

    // Out-of-order writeback, in-order commit
    for (int i = 0; i < 3; i++) begin issue_set(ROBK_REG, 5'(i + 1), 0, 0); tick(); end
    idle();
    wv[0] = 1; wid[0] = 2; wval[0] = 32'hC2; tick();
    wid[0] = 0; wval[0] = 32'hC0; tick();
    wid[0] = 1; wval[0] = 32'hC1;
    settle(); chk("ooo_c0", {bus.commit_valid, bus.commit_id}, {1'b1, 4'd0}); check_outputs(); advance();
    wv[0] = 0;
    settle(); chk("ooo_c1", {bus.commit_valid, bus.commit_id}, {1'b1, 4'd1});
    chk("ooo_v1", bus.commit_value, 32'hC1); check_outputs(); advance();
    settle(); chk("ooo_c2", {bus.commit_valid, bus.commit_id}, {1'b1, 4'd2}); check_outputs(); advance();
    settle(); chk("ooo_empty", bus.count, 0); check_outputs(); advance();
    do_reset();

    // Store waits for LSB acknowledge
    issue_set(ROBK_STORE, 0, 1, 32'h55); tick(); idle();
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("st_req_wait", bus.st_commit_req, 1);
      chk("st_head_fixed", bus.head_id, 0);
      check_outputs(); advance();
    end
    ack = 1; settle(); chk("st_req_ack", bus.st_commit_req, 1); check_outputs(); advance(); ack = 0;
    settle(); chk("st_retired", bus.count, 0); chk("st_head_next", bus.head_id, 1);
    check_outputs(); advance();
    do_reset();

    // Mispredicted branch at tag 5
    for (int i = 0; i < 5; i++) begin issue_set(ROBK_REG, 5'(i + 1), 0, 0); tick(); end
    issue_set(ROBK_BRANCH, 0, 0, 0); tick();
    issue_set(ROBK_REG, 9, 0, 0); tick(); idle();
    wv[1] = 1; wid[1] = 5; wmp[1] = 1; wred[1] = 32'h1000; wval[1] = 0; tick();
    wv[1] = 0; wmp[1] = 0;
    for (int i = 0; i < 5; i++) begin wv[0] = 1; wid[0] = 4'(i); wval[0] = 32'(i * 16); tick(); end
    wv[0] = 0;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      settle();
      if (bus.flush === 1'b1) begin
        seen = 1;
        chk("mp_flush_pc", bus.flush_pc, 32'h1000);
        chk("mp_commit", {bus.commit_valid, bus.commit_id}, {1'b1, 4'd5});
      end
      check_outputs(); advance();
    end
    chk("mp_flush_seen", seen, 1);
    settle(); chk("mp_empty", bus.count, 0); chk("mp_alloc", bus.alloc_id, 0);
    check_outputs(); advance();
    do_reset();

    // Query readiness around a writeback, plus same-tag port collision
    for (int i = 0; i < 4; i++) begin issue_set(ROBK_REG, 5'(i + 1), 0, 0); tick(); end
    idle();
    wv[1] = 1; wid[1] = 3; wval[1] = 32'h2A; qid[0] = 3;
    settle();
`ifdef ROB_WB_BYPASS_EN
    chk("byp_ready_now", bus.q_ready[0], 1);
    chk("byp_value_now", bus.q_value[31:0], 32'h2A);
`else
    chk("byp_ready_now", bus.q_ready[0], 0);
`endif
    check_outputs(); advance();
    wv[1] = 0;
    settle(); chk("byp_ready_next", bus.q_ready[0], 1); chk("byp_value_next", bus.q_value[31:0], 32'h2A);
    check_outputs(); advance();
    wv[0] = 1; wid[0] = 1; wval[0] = 32'h11; wv[1] = 1; wid[1] = 1; wval[1] = 32'h22; qid[1] = 1;
    tick(); wv[0] = 0; wv[1] = 0;
    settle(); chk("collide_hi_wins", bus.q_value[63:32], 32'h22); check_outputs(); advance();
    do_reset();

    // rdy low freezes commit
    issue_set(ROBK_REG, 3, 1, 32'h77); tick(); idle();
    rdy = 0; settle(); chk("rdy0_commit", bus.commit_valid, 0); check_outputs(); advance();
    rdy = 1; settle(); chk("rdy1_commit", bus.commit_valid, 1); check_outputs(); advance();

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      rdy  = ($urandom_range(0, 9) != 0);
      rst  = ($urandom_range(0, 99) == 0);
      iv   = ($urandom_range(0, 9) < 6);
      ik   = 3'($urandom_range(0, 4));
      ird  = 5'($urandom);
      ipc  = $urandom;
      ival = $urandom;
      idn  = ($urandom_range(0, 3) == 0);
      for (int p = 0; p < WBP; p++) begin
        wv[p]   = 1'($urandom_range(0, 1));
        wid[p]  = (mq.size() > 0 && $urandom_range(0, 4) != 0) ?
                  4'(mq[$urandom_range(0, mq.size() - 1)].id) : 4'($urandom);
        wval[p] = $urandom;
        wmp[p]  = ($urandom_range(0, 15) == 0);
        wred[p] = $urandom;
      end
      for (int q = 0; q < QP; q++) qid[q] = 4'($urandom);
      ack = 1'($urandom_range(0, 1));
      tick();
    end
    rst = 0; rdy = 1;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
